// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-side memory access unit.
// Access-length codes match the decoder's memory-length encoding (B/H/W/WL/WR).
// Optional build macro: MEM_UNALIGNED_EXC_EN (see mem_access_unit.sv).
package mem_access_unit_pkg;

    // Access length codes driven by the decoder on its 3-bit length output
    localparam logic [2:0] MEM_LEN_B  = 3'd0;
    localparam logic [2:0] MEM_LEN_H  = 3'd1;
    localparam logic [2:0] MEM_LEN_W  = 3'd2;
    localparam logic [2:0] MEM_LEN_WL = 3'd3;
    localparam logic [2:0] MEM_LEN_WR = 3'd4;

    // Transaction FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Byte offset actually used on the bus: H keeps only bit 1, W (and any
    // unknown length, which behaves as W) is always word aligned.
    function automatic logic [1:0] normOffset(input logic [2:0] len, input logic [1:0] off);
        case (len)
            MEM_LEN_B, MEM_LEN_WL, MEM_LEN_WR: return off;
            MEM_LEN_H:                         return {off[1], 1'b0};
            default:                           return 2'b00;
        endcase
    endfunction

    // True when the natural alignment of the access is violated.
    // B, WL and WR are legal at any offset.
    function automatic logic isMisaligned(input logic [2:0] len, input logic [1:0] off);
        case (len)
            MEM_LEN_B, MEM_LEN_WL, MEM_LEN_WR: return 1'b0;
            MEM_LEN_H:                         return off[0];
            default:                           return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational byte-lane steering for the memory access unit.
// Stores: byte enables and lane-shifted write data.
// Loads: byte/half extraction with zero/sign extension, and the LWL/LWR
// merge of bus data into the old register value. Little-endian.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  len,
    input  logic        sgn,
    input  logic [1:0]  off,
    input  logic [31:0] storeData,
    input  logic [31:0] memData,
    input  logic [31:0] rtOld,
    output logic [3:0]  be,
    output logic [31:0] busData,
    output logic [31:0] loadData
);

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic [4:0]  shO;       // 8*o
    logic [4:0]  shInvO;    // 8*(3-o)
    logic [31:0] memShr;    // bus word moved so that byte o sits in lane 0

    assign shO    = {off, 3'b000};
    assign shInvO = {~off, 3'b000};
    assign memShr = memData >> shO;

    // Lane selection per access length; unknown lengths fall back to W
    always_comb begin
        be       = 4'hF;
        busData  = storeData;
        loadData = memData;
        case (len)
            MEM_LEN_B: begin
                be       = 4'b0001 << off;
                busData  = {4{storeData[7:0]}};
                loadData = {{24{sgn & memShr[7]}}, memShr[7:0]};
            end
            MEM_LEN_H: begin
                be       = 4'b0011 << off;
                busData  = {2{storeData[15:0]}};
                loadData = {{16{sgn & memShr[15]}}, memShr[15:0]};
            end
            MEM_LEN_WL: begin
                case (off)
                    2'd0:    be = 4'b0001;
                    2'd1:    be = 4'b0011;
                    2'd2:    be = 4'b0111;
                    default: be = 4'b1111;
                endcase
                busData  = storeData >> shInvO;
                loadData = (memData << shInvO) | (rtOld & ~(ALL_ONES << shInvO));
            end
            MEM_LEN_WR: begin
                be       = 4'hF << off;
                busData  = storeData << shO;
                loadData = memShr | (rtOld & ~(ALL_ONES >> shO));
            end
            default: begin
                be       = 4'hF;
                busData  = storeData;
                loadData = memData;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-side memory port: one load/store per transaction on a word-wide bus
// with byte enables, returning the aligned/extended/merged load result.
// Optional macro MEM_UNALIGNED_EXC_EN: misaligned H/W accesses finish with
// addr_err and no bus cycle. Without it, addr_err is 0 and the low address
// bits of H/W accesses are forced to their aligned values.
// TIMEOUT_CYCLES must fit in the counter: 2**CNT_W > TIMEOUT_CYCLES.
//
// Handshake: req is sampled only while busy==0 and with exactly one of
// read/write set; anything else is dropped, not queued. mem_req stays high
// with stable mem_we/mem_addr/mem_be/mem_wdata until the cycle mem_ack is
// seen; mem_ack outside that window is ignored. done is a one-cycle pulse,
// with rdata/addr_err/bus_err valid alongside it.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  len,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Captured request
    logic [2:0]  lenQ;
    logic        sgnQ;
    logic [1:0]  offQ;
    logic [31:0] rtOldQ;

    // Registered outputs
    logic        busyQ;
    logic        doneQ;
    logic [31:0] rdataQ;
    logic        addrErrQ;
    logic        busErrQ;
    logic        memReqQ;
    logic        memWeQ;
    logic [31:0] memAddrQ;
    logic [3:0]  memBeQ;
    logic [31:0] memWdataQ;

    logic        accept;
    logic        misalignedNow;
    logic [1:0]  offNorm;
    logic [2:0]  alignLen;
    logic [1:0]  alignOff;
    logic [3:0]  alignBe;
    logic [31:0] alignBusData;
    logic [31:0] alignLoadData;

    assign accept  = (state == ST_IDLE) && req && (read ^ write);
    assign offNorm = normOffset(len, addr[1:0]);

`ifdef MEM_UNALIGNED_EXC_EN
    assign misalignedNow = isMisaligned(len, addr[1:0]);
`else
    assign misalignedNow = 1'b0;
`endif

    // In IDLE the lane logic sees the live request (store lanes, enables);
    // afterwards it sees the captured request (load extract/merge).
    assign alignLen = (state == ST_IDLE) ? len     : lenQ;
    assign alignOff = (state == ST_IDLE) ? offNorm : offQ;

    mem_lane_align uLane (
        .len       (alignLen),
        .sgn       (sgnQ),
        .off       (alignOff),
        .storeData (wdata),
        .memData   (mem_rdata),
        .rtOld     (rtOldQ),
        .be        (alignBe),
        .busData   (alignBusData),
        .loadData  (alignLoadData)
    );

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lenQ      <= 3'd0;
            sgnQ      <= 1'b0;
            offQ      <= 2'd0;
            rtOldQ    <= 32'd0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
            rdataQ    <= 32'd0;
            addrErrQ  <= 1'b0;
            busErrQ   <= 1'b0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= 32'd0;
            memBeQ    <= 4'd0;
            memWdataQ <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busyQ  <= 1'b1;
                        lenQ   <= len;
                        sgnQ   <= sgn;
                        offQ   <= offNorm;
                        rtOldQ <= rt_old;
                        cnt    <= '0;
                        if (misalignedNow) begin
                            // Rejected without touching the bus
                            addrErrQ <= 1'b1;
                            doneQ    <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            memReqQ   <= 1'b1;
                            memWeQ    <= write;
                            memAddrQ  <= {addr[31:2], 2'b00};
                            memBeQ    <= alignBe;
                            memWdataQ <= alignBusData;
                            state     <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        memReqQ <= 1'b0;
                        doneQ   <= 1'b1;
                        if (!memWeQ) begin
                            rdataQ <= alignLoadData;
                        end
                        state <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        memReqQ <= 1'b0;
                        busErrQ <= 1'b1;
                        doneQ   <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    doneQ    <= 1'b0;
                    busyQ    <= 1'b0;
                    busErrQ  <= 1'b0;
                    addrErrQ <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busyQ;
    assign done      = doneQ;
    assign rdata     = rdataQ;
    assign addr_err  = addrErrQ;
    assign bus_err   = busErrQ;
    assign mem_req   = memReqQ;
    assign mem_we    = memWeQ;
    assign mem_addr  = memAddrQ;
    assign mem_be    = memBeQ;
    assign mem_wdata = memWdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. A driver issues requests and plays
// the bus responder; each expected response {check_rdata, addr_err,
// bus_err, rdata} is queued and a monitor compares it when done pulses.
module tb_mem_access_unit;

    localparam int TIMEOUT = 256;

    localparam logic [2:0] L_B  = 3'd0;
    localparam logic [2:0] L_H  = 3'd1;
    localparam logic [2:0] L_W  = 3'd2;
    localparam logic [2:0] L_WL = 3'd3;
    localparam logic [2:0] L_WR = 3'd4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req, read, write, sgn, memAck;
    logic [2:0]  len;
    logic [31:0] addr, wdata, rtOld, memRdata;
    logic        busy, done, addrErr, busErr, memReq, memWe;
    logic [31:0] rdata, memAddr, memWdata;
    logic [3:0]  memBe;

    logic [34:0] expQ[$];
    logic [31:0] lastRdata;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(9)) dut (
        .clk(clk), .rst_n(rstN), .req(req), .read(read), .write(write),
        .len(len), .sgn(sgn), .addr(addr), .wdata(wdata), .rt_old(rtOld),
        .busy(busy), .done(done), .rdata(rdata), .addr_err(addrErr),
        .bus_err(busErr), .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr),
        .mem_be(memBe), .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ack(memAck)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the head of the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rstN && done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no response");
                end else begin
                    logic [34:0] e;
                    e = expQ.pop_front();
                    check("resp_addr_err", {31'd0, addrErr}, {31'd0, e[33]});
                    check("resp_bus_err", {31'd0, busErr}, {31'd0, e[32]});
                    if (e[34]) check("resp_rdata", rdata, e[31:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Issue one request (called at a negedge) and act as the bus.
    // ackDelay < 0 means never acknowledge (timeout expected).
    task automatic doAccess(input logic rd, input logic [2:0] ln, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rt,
                            input logic [31:0] md, input int ackDelay,
                            input logic [3:0] expBe, input logic chkWd, input logic [31:0] expWd,
                            input logic [31:0] expRd, input logic pokeBusy);
        int n;
        if (ackDelay < 0) expQ.push_back({1'b0, 1'b0, 1'b1, 32'd0});
        else begin
            if (rd) lastRdata = expRd;
            expQ.push_back({1'b1, 1'b0, 1'b0, lastRdata});
        end
        req = 1'b1; read = rd; write = ~rd; len = ln; sgn = sg;
        addr = a; wdata = wd; rtOld = rt;
        @(posedge clk); #1;
        req = 1'b0;
        check("mem_req_rise", {31'd0, memReq}, 32'd1);
        check("busy_set", {31'd0, busy}, 32'd1);
        check("mem_we", {31'd0, memWe}, {31'd0, ~rd});
        check("mem_addr", memAddr, {a[31:2], 2'b00});
        check("mem_be", {28'd0, memBe}, {28'd0, expBe});
        if (chkWd) check("mem_wdata", memWdata, expWd);
        @(negedge clk);
        if (ackDelay < 0) begin
            n = 0;
            while (!done && n < TIMEOUT + 100) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, TIMEOUT);
        end else begin
            for (int i = 0; i < ackDelay; i++) begin
                if (pokeBusy && i == 0) begin
                    req = 1'b1; read = 1'b1; write = 1'b0; addr = 32'hDEAD_BEE0;
                end
                @(negedge clk);
                req = 1'b0;
                check("mem_req_hold", {31'd0, memReq}, 32'd1);
                check("mem_addr_hold", memAddr, {a[31:2], 2'b00});
            end
            memAck = 1'b1; memRdata = md;
            @(negedge clk);
            memAck = 1'b0; memRdata = 32'h0;
            check("done_after_ack", {31'd0, done}, 32'd1);
            check("mem_req_drop", {31'd0, memReq}, 32'd0);
        end
        @(negedge clk);
        check("busy_clear", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    // Main stimulus
    initial begin
        rstN = 1'b0; req = 1'b0; read = 1'b0; write = 1'b0; len = 3'd0; sgn = 1'b0;
        addr = 32'd0; wdata = 32'd0; rtOld = 32'd0; memRdata = 32'd0; memAck = 1'b0;
        lastRdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", {31'd0, memReq}, 32'd0);
        check("rst_mem_be", {28'd0, memBe}, 32'd0);
        check("rst_mem_addr", memAddr, 32'd0);
        check("rst_mem_wdata", memWdata, 32'd0);
        check("rst_errs", {30'd0, addrErr, busErr}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // rd len sg addr wdata rt_old mem_rdata ack be chkWd expWd expRd poke
        doAccess(1, L_B, 1, 32'h103, 32'h0, 32'h0, 32'h80FF0011, 0, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 0);
        doAccess(1, L_H, 0, 32'h102, 32'h0, 32'h0, 32'hBEEF1234, 0, 4'b1100, 0, 32'h0, 32'h0000BEEF, 0);
        doAccess(0, L_WL, 0, 32'h201, 32'hAABBCCDD, 32'h0, 32'h0, 2, 4'b0011, 1, 32'h0000AABB, 32'h0, 0);
        doAccess(1, L_WR, 0, 32'h302, 32'h0, 32'h11223344, 32'h55667788, 1, 4'b1100, 0, 32'h0, 32'h11225566, 0);
        doAccess(1, L_WL, 0, 32'h301, 32'h0, 32'h11223344, 32'h55667788, 0, 4'b0011, 0, 32'h0, 32'h77883344, 0);
        doAccess(0, L_B, 0, 32'h002, 32'h123456AB, 32'h0, 32'h0, 0, 4'b0100, 1, 32'hABABABAB, 32'h0, 0);
        doAccess(0, L_WR, 0, 32'h003, 32'hAABBCCDD, 32'h0, 32'h0, 0, 4'b1000, 1, 32'hDD000000, 32'h0, 0);
        doAccess(0, L_H, 0, 32'h006, 32'h0000BEEF, 32'h0, 32'h0, 0, 4'b1100, 1, 32'hBEEFBEEF, 32'h0, 0);
        doAccess(1, L_H, 1, 32'h000, 32'h0, 32'h0, 32'h12348001, 0, 4'b0011, 0, 32'h0, 32'hFFFF8001, 0);
        doAccess(1, L_W, 0, 32'h404, 32'h0, 32'h0, 32'hCAFEF00D, 3, 4'b1111, 0, 32'h0, 32'hCAFEF00D, 1);
        doAccess(1, 3'd7, 1, 32'h50C, 32'h0, 32'h0, 32'h8765_4321, 0, 4'b1111, 0, 32'h0, 32'h87654321, 0);

`ifdef MEM_UNALIGNED_EXC_EN
        // Misaligned W: rejected with addr_err, no bus cycle
        expQ.push_back({1'b0, 1'b1, 1'b0, 32'd0});
        req = 1'b1; read = 1'b1; write = 1'b0; len = L_W; addr = 32'h401;
        @(posedge clk); #1;
        req = 1'b0;
        check("unaligned_no_mem_req", {31'd0, memReq}, 32'd0);
        @(negedge clk);
        check("unaligned_done", {31'd0, done}, 32'd1);
        check("unaligned_no_mem_req2", {31'd0, memReq}, 32'd0);
        @(negedge clk);
`else
        // Misaligned W/H: low address bits forced to aligned values
        doAccess(1, L_W, 0, 32'h401, 32'h0, 32'h0, 32'h0BADF00D, 0, 4'b1111, 0, 32'h0, 32'h0BADF00D, 0);
        doAccess(1, L_H, 0, 32'h103, 32'h0, 32'h0, 32'hABCD1234, 0, 4'b1100, 0, 32'h0, 32'h0000ABCD, 0);
`endif

        // No ack: bus error after the timeout
        doAccess(1, L_W, 0, 32'h600, 32'h0, 32'h0, 32'h0, -1, 4'b1111, 0, 32'h0, 32'h0, 0);

        // read and write together: ignored
        req = 1'b1; read = 1'b1; write = 1'b1; len = L_W; addr = 32'h700;
        @(posedge clk); #1;
        req = 1'b0; write = 1'b0;
        check("rw_ignored_busy", {31'd0, busy}, 32'd0);
        check("rw_ignored_mem_req", {31'd0, memReq}, 32'd0);
        @(negedge clk);

        // Stray ack while idle: ignored
        memAck = 1'b1; memRdata = 32'h1234_5678;
        @(negedge clk);
        memAck = 1'b0;
        check("stray_ack_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("stray_ack_done", {31'd0, done}, 32'd0);

        // Reset in the middle of an access
        req = 1'b1; read = 1'b1; write = 1'b0; len = L_W; addr = 32'h800;
        @(posedge clk); #1;
        req = 1'b0;
        check("pre_rst_mem_req", {31'd0, memReq}, 32'd1);
        repeat (3) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        check("async_rst_mem_req", {31'd0, memReq}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        lastRdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        doAccess(1, L_B, 0, 32'h901, 32'h0, 32'h0, 32'h0000_C300, 0, 4'b0010, 0, 32'h0, 32'h000000C3, 0);

        repeat (2) @(negedge clk);
        check("queue_empty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
